accel_op_sequencer: RTL and testbench
=====================================

// Module: accel_op_sequencer
// PURPOSE
//  Sequencing controller for the peripheral's operand/opcode register set: on a start strobe it latches
//  operands A..D and a 4-bit opcode, runs single-cycle or iterative multi-cycle ALU ops (shift-add MUL,
//  dual-MUL MAC, restoring DIV) and posts a registered result with busy/done/error status.
//  Sits between the bus register file (drives start/op/a..d) and the readable result/status registers.
// PARAMETERS
//  W  8  operand width; result is 2W bits; MUL/DIV iterate W cycles, MAC 2W cycles
// PORTS
//  clk     in   1   project clock
//  rst     in   1   reset: one clock; reset is synchronous and active-high
//  start   in   1   op request, sampled every rising edge
//  op      in   4   opcode, sampled with start
//  a,b,c,d in   W   operands, sampled with start
//  abort   in   1   cancel in-flight op
//  busy    out  1   op in progress
//  done    out  1   one-cycle completion pulse
//  result  out  2W  last completed result, held until next completion
//  err     out  1   error flag of last completed op, held with result
//  ovr     out  1   sticky: start arrived while busy
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0, err=0, ovr=0; iteration counter and operand latches cleared.
//  FSM states:
//   - IDLE: start=1 -> latch op,a,b,c,d; load counter with N-1; clear ovr -> EXEC.
//   - EXEC: busy=1; one iteration per cycle. Count==0 -> FINISH.
//     abort=1 -> IDLE: no done, result/err unchanged.
//   - FINISH: result/err registered; done=1, busy=0 for this cycle -> IDLE.
//  Timing: start accepted at edge k -> busy=1 in cycles k+1..k+N -> done=1, busy=0, result valid from k+N+1.
//  Back-to-back: start is accepted in the done cycle (FINISH counts as idle for acceptance).
//   No bubble: the next done follows N+1 cycles later.
//  start while busy (EXEC): ignored, ovr<=1; ovr holds until the next accepted start.
//  abort and count==0 on the same edge: abort wins.
//  abort in IDLE/FINISH: no effect.
//  rst mid-op: all state returns to reset values in the next cycle.
//  Ops (operands unsigned, zero-extended to 2W; all results mod 2^2W):
//   0 NOP  N=1  result=0, err=0
//   1 ADD  N=1  a+b (carry lands in bit W)
//   2 SUB  N=1  a-b two's complement over 2W bits
//   3 AND  N=1  bitwise, upper W bits zero
//   4 OR   N=1  bitwise, upper W bits zero
//   5 XOR  N=1  bitwise, upper W bits zero
//   6 MUL  N=W   a*b via shift-add, one partial product per cycle
//   7 MAC  N=2W  a*b, then c*d into the same accumulator; err=1 if the accumulated sum carries out of 2W bits
//   8 DIV  N=W  restoring division; result={remainder[W-1:0], quotient[W-1:0]}
//     b==0: N=1, err=1, result={a, {W{1'b1}}}
//   9-15 illegal  N=1  err=1, result=0
//  Invariants:
//   - done and busy are never high together.
//   - Latched operands are immune to input changes after acceptance.
//   - result/err change only in the done cycle.
// TESTING
//  ADD: rst; start op=1 a=200 b=100 -> busy 1 cycle; done next; result=16'h012C, err=0.
//  MUL: op=6 a=13 b=11 -> busy exactly 8 cycles; done; result=143.
//   Hold start high during busy -> ovr=1; result stays 143.
//  DIV: op=8 a=100 b=7 -> done after 8 busy cycles; result=16'h020E.
//   Then op=8 a=5 b=0 -> 1 busy cycle; result=16'h05FF, err=1.
//  MAC overflow: op=7 a=b=c=d=255 -> 16 busy cycles; result=16'hFC02, err=1.
//   Illegal op=12 -> result=0, err=1.
//  Abort mid-MUL after 3 cycles -> busy=0 next cycle; no done; result/err keep prior values.
//   Start in the done cycle of an ADD -> accepted, no bubble.
//  Reset: rst pulse mid-MAC -> all outputs 0 next cycle.
//   Abort and final iteration on the same edge -> no done.

Source files
------------

// File: rtl/accel_op_sequencer.sv
// Operand/opcode sequencer: latches a start request, runs a single-cycle or iterative
// ALU op (shift-add MUL, dual-product MAC, restoring DIV) and posts a registered result.
module accel_op_sequencer #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [3:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   c,
    input  logic [W-1:0]   d,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           err,
    output logic           ovr
);

    localparam int unsigned CntW = $clog2(2 * W) + 1;

    localparam logic [3:0] OpNop = 4'd0;
    localparam logic [3:0] OpAdd = 4'd1;
    localparam logic [3:0] OpSub = 4'd2;
    localparam logic [3:0] OpAnd = 4'd3;
    localparam logic [3:0] OpOr  = 4'd4;
    localparam logic [3:0] OpXor = 4'd5;
    localparam logic [3:0] OpMul = 4'd6;
    localparam logic [3:0] OpMac = 4'd7;
    localparam logic [3:0] OpDiv = 4'd8;

    typedef enum logic [1:0] {StIdle, StExec, StFinish} state_e;

    state_e          state_q;
    logic [3:0]      op_q;
    logic [W-1:0]    a_q, b_q, c_q, d_q;
    logic [CntW-1:0] cnt_q;
    logic [2*W-1:0]  acc_q, md_q;
    logic [W-1:0]    mr_q;
    logic            cy_q;

    logic [2*W-1:0]  acc_d, md_d, res_d;
    logic [W-1:0]    mr_d;
    logic            cy_d, err_d;
    logic [2*W:0]    sum;
    logic [W:0]      rem_sh, trial;
    logic [2*W-1:0]  ea, eb;

    // Index of the last iteration, i.e. N-1 for the requested op.
    function automatic logic [CntW-1:0] last_iter(input logic [3:0] opc,
                                                  input logic [W-1:0] divisor);
        case (opc)
            OpMul:   last_iter = CntW'(W - 1);
            OpMac:   last_iter = CntW'(2 * W - 1);
            OpDiv:   last_iter = (divisor == '0) ? '0 : CntW'(W - 1);
            default: last_iter = '0;
        endcase
    endfunction

    always_comb begin
        acc_d  = acc_q;
        md_d   = md_q;
        mr_d   = mr_q;
        cy_d   = cy_q;
        res_d  = '0;
        err_d  = 1'b0;
        ea     = {{W{1'b0}}, a_q};
        eb     = {{W{1'b0}}, b_q};
        sum    = {1'b0, acc_q} + {1'b0, (mr_q[0] ? md_q : '0)};
        rem_sh = {acc_q[W-1:0], mr_q[W-1]};
        trial  = rem_sh - {1'b0, b_q};
        case (op_q)
            OpNop: res_d = '0;
            OpAdd: res_d = ea + eb;
            OpSub: res_d = ea - eb;
            OpAnd: res_d = ea & eb;
            OpOr:  res_d = ea | eb;
            OpXor: res_d = ea ^ eb;
            OpMul, OpMac: begin
                acc_d = sum[2*W-1:0];
                md_d  = md_q << 1;
                mr_d  = mr_q >> 1;
                if (op_q == OpMac) begin
                    cy_d = cy_q | sum[2*W];
                    // First product finished: restart the shifter on c*d.
                    if (cnt_q == CntW'(W)) begin
                        md_d = {{W{1'b0}}, c_q};
                        mr_d = d_q;
                    end
                end
                res_d = acc_d;
                err_d = cy_d;
            end
            OpDiv: begin
                if (b_q == '0) begin
                    res_d = {a_q, {W{1'b1}}};
                    err_d = 1'b1;
                end else begin
                    if (!trial[W]) begin
                        acc_d = {{W{1'b0}}, trial[W-1:0]};
                        mr_d  = {mr_q[W-2:0], 1'b1};
                    end else begin
                        acc_d = {{W{1'b0}}, rem_sh[W-1:0]};
                        mr_d  = {mr_q[W-2:0], 1'b0};
                    end
                    res_d = {acc_d[W-1:0], mr_d};
                end
            end
            default: begin
                res_d = '0;
                err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            md_q    <= '0;
            mr_q    <= '0;
            cy_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            err     <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_q != StExec) begin
                // FINISH accepts a new start just like IDLE.
                state_q <= StIdle;
                if (start) begin
                    state_q <= StExec;
                    busy    <= 1'b1;
                    ovr     <= 1'b0;
                    op_q    <= op;
                    a_q     <= a;
                    b_q     <= b;
                    c_q     <= c;
                    d_q     <= d;
                    cnt_q   <= last_iter(op, b);
                    acc_q   <= '0;
                    md_q    <= {{W{1'b0}}, a};
                    mr_q    <= (op == OpDiv) ? a : b;
                    cy_q    <= 1'b0;
                end
            end else begin
                if (start) begin
                    ovr <= 1'b1;
                end
                if (abort) begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end else begin
                    acc_q <= acc_d;
                    md_q  <= md_d;
                    mr_q  <= mr_d;
                    cy_q  <= cy_d;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_q <= StFinish;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= res_d;
                        err     <= err_d;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_accel_op_sequencer.sv
// Directed bench for accel_op_sequencer: a vector table of ops plus hand-written
// sequences for overrun, abort, back-to-back and mid-op reset.
module tb_accel_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [7:0]  a = '0, b = '0, c = '0, d = '0;
    logic        abort = 1'b0;
    logic        busy, done, err, ovr;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;
    logic both_seen = 1'b0;

    accel_op_sequencer #(.W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err),
        .ovr    (ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [7:0]  a, b, c, d;
        int          nbusy;
        logic [15:0] res;
        logic        err;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one op and wait (bounded) for done; returns in the done cycle.
    task automatic run_op(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] vc, input logic [7:0] vd,
                          output int nb, output logic seen);
        @(negedge clk);
        op = o; a = va; b = vb; c = vc; d = vd; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'd1; a = ~va; b = ~vb; c = 8'h5a; d = 8'ha5;
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy && done) both_seen = 1'b1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int budget, output int nb, output logic seen);
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy && done) both_seen = 1'b1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
        end
    endtask

    initial begin
        int nb;
        logic seen;
        logic any_done;

        vecs[0]  = '{"add",     4'd1,  8'd200, 8'd100, 8'd0,   8'd0,   1,  16'h012c, 1'b0};
        vecs[1]  = '{"add_cy",  4'd1,  8'd255, 8'd255, 8'd0,   8'd0,   1,  16'h01fe, 1'b0};
        vecs[2]  = '{"sub_neg", 4'd2,  8'd5,   8'd7,   8'd0,   8'd0,   1,  16'hfffe, 1'b0};
        vecs[3]  = '{"and",     4'd3,  8'hf0,  8'h3c,  8'd0,   8'd0,   1,  16'h0030, 1'b0};
        vecs[4]  = '{"or",      4'd4,  8'hf0,  8'h0f,  8'd0,   8'd0,   1,  16'h00ff, 1'b0};
        vecs[5]  = '{"xor",     4'd5,  8'haa,  8'hff,  8'd0,   8'd0,   1,  16'h0055, 1'b0};
        vecs[6]  = '{"nop",     4'd0,  8'd9,   8'd9,   8'd0,   8'd0,   1,  16'h0000, 1'b0};
        vecs[7]  = '{"mul",     4'd6,  8'd13,  8'd11,  8'd0,   8'd0,   8,  16'h008f, 1'b0};
        vecs[8]  = '{"mul_max", 4'd6,  8'd255, 8'd255, 8'd0,   8'd0,   8,  16'hfe01, 1'b0};
        vecs[9]  = '{"div",     4'd8,  8'd100, 8'd7,   8'd0,   8'd0,   8,  16'h020e, 1'b0};
        vecs[10] = '{"div_z",   4'd8,  8'd5,   8'd0,   8'd0,   8'd0,   1,  16'h05ff, 1'b1};
        vecs[11] = '{"div_by1", 4'd8,  8'd255, 8'd1,   8'd0,   8'd0,   8,  16'h00ff, 1'b0};
        vecs[12] = '{"div_sm",  4'd8,  8'd3,   8'd10,  8'd0,   8'd0,   8,  16'h0300, 1'b0};
        vecs[13] = '{"mac_ovf", 4'd7,  8'd255, 8'd255, 8'd255, 8'd255, 16, 16'hfc02, 1'b1};
        vecs[14] = '{"mac",     4'd7,  8'd2,   8'd3,   8'd4,   8'd5,   16, 16'h001a, 1'b0};
        vecs[15] = '{"illegal", 4'd12, 8'd1,   8'd2,   8'd0,   8'd0,   1,  16'h0000, 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_status", {busy, done, err, ovr}, 4'b0000);
        chk("reset_result", result, 16'h0000);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {busy, done, err}, 3'b000);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, nb, seen);
            chk({vecs[i].name, "_done"},  seen, 1'b1);
            chk({vecs[i].name, "_nbusy"}, nb, vecs[i].nbusy);
            chk({vecs[i].name, "_res"},   result, vecs[i].res);
            chk({vecs[i].name, "_err"},   err, vecs[i].err);
        end

        // Start held high during a MUL sets ovr; the busy op is not disturbed.
        @(negedge clk);
        op = 4'd6; a = 8'd13; b = 8'd11; start = 1'b1;
        @(negedge clk);
        op = 4'd1; a = 8'd1; b = 8'd1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(20, nb, seen);
        chk("ovr_done", seen, 1'b1);
        chk("ovr_nbusy", nb, 32'd5);
        chk("ovr_res", result, 16'h008f);
        chk("ovr_set", ovr, 1'b1);
        run_op(4'd1, 8'd1, 8'd2, 8'd0, 8'd0, nb, seen);
        chk("ovr_clear", ovr, 1'b0);
        chk("ovr_next_res", result, 16'h0003);

        // Abort mid-MUL: prior result/err (from DIV by zero) must survive.
        run_op(4'd8, 8'd5, 8'd0, 8'd0, 8'd0, nb, seen);
        @(negedge clk);
        op = 4'd6; a = 8'd13; b = 8'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        any_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            any_done |= done;
            @(negedge clk);
        end
        chk("abort_no_done", any_done, 1'b0);
        chk("abort_res", result, 16'h05ff);
        chk("abort_err", err, 1'b1);

        // Abort coinciding with the final MUL iteration: abort wins.
        op = 4'd6; a = 8'd3; b = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_last_busy", busy, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_last", {busy, done}, 2'b00);
        any_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            any_done |= done;
            @(negedge clk);
        end
        chk("abort_last_no_done", any_done, 1'b0);
        chk("abort_last_res", result, 16'h05ff);

        // Start in the done cycle of an ADD: accepted with no bubble.
        run_op(4'd1, 8'd10, 8'd20, 8'd0, 8'd0, nb, seen);
        chk("b2b_first", result, 16'h001e);
        op = 4'd1; a = 8'd7; b = 8'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {busy, done}, 2'b10);
        @(negedge clk);
        chk("b2b_done", {busy, done}, 2'b01);
        chk("b2b_res", result, 16'h000f);

        // Reset pulse mid-MAC (ovr set beforehand) clears every output.
        @(negedge clk);
        op = 4'd7; a = 8'd255; b = 8'd255; c = 8'd255; d = 8'd255; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_ovr", ovr, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_status", {busy, done, err, ovr}, 4'b0000);
        chk("rst_mid_res", result, 16'h0000);
        run_op(4'd2, 8'd9, 8'd4, 8'd0, 8'd0, nb, seen);
        chk("rst_recover", result, 16'h0005);

        chk("busy_done_excl", both_seen, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
